// File: rtl/pro_uart_meas_if.sv
// rtl/pro_uart_meas_if.sv - Signal and result bundle for the frequency/phase meter
//   sig_in  : reference square wave A (asynchronous)
//   sig_in1 : second square wave B (asynchronous)
//   phase   : B lag relative to A (raw clocks, or 0.1 deg with PHASE_DEG_EN)
//   pinlv   : rising edges of A in the last complete gate
interface pro_uart_meas_if;
    logic        sig_in;
    logic        sig_in1;
    logic [31:0] phase;
    logic [31:0] pinlv;

    modport master (output sig_in, output sig_in1, input phase, input pinlv);
    modport slave  (input sig_in, input sig_in1, output phase, output pinlv);
endinterface

// File: rtl/pro_uart_meas.sv
// rtl/pro_uart_meas.sv - Dual-input frequency and phase-lag meter
//   clk   : system clock
//   rst_n : asynchronous reset, active HIGH (name inherited)
//   io    : slave modport carrying sig_in, sig_in1 in and phase, pinlv out
//   Optional macro PHASE_DEG_EN: phase = floor(D*3600/P) via a sequential
//   restoring divider; otherwise phase = D in clock cycles.
module pro_uart_meas #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int DIV_W       = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pro_uart_meas_if.slave io
);
    localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, WAIT_B, WAIT_A, DIV} state_t;

    // pipe[0], pipe[1]: synchronizer stages; pipe[2]: previous synced value
    logic [2:0]  a_pipe_q, a_pipe_d, b_pipe_q, b_pipe_d;
    logic        rise_a_q, rise_a_d, rise_b_q, rise_b_d;
    logic [31:0] gate_q, gate_d, edge_q, edge_d, pinlv_q, pinlv_d, edge_inc;
    state_t      state_q, state_d;
    logic [31:0] per_q, per_d, dly_q, dly_d, per_inc, dly_inc;
    logic [31:0] d_lat_q, d_lat_d, phase_q, phase_d;

`ifdef PHASE_DEG_EN
    localparam int STEP_W = $clog2(DIV_W + 2);

    logic [31:0]       p_lat_q, p_lat_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DIV_W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dividend;
    logic [DIV_W:0]    rem_sh;
    logic [43:0]       prod;
`endif

    always_comb begin
        a_pipe_d = {a_pipe_q[1:0], io.sig_in};
        b_pipe_d = {b_pipe_q[1:0], io.sig_in1};
        rise_a_d = a_pipe_q[1] & ~a_pipe_q[2];
        rise_b_d = b_pipe_q[1] & ~b_pipe_q[2];

        // Frequency gate
        gate_d   = gate_q + 32'd1;
        edge_d   = edge_q;
        pinlv_d  = pinlv_q;
        edge_inc = (edge_q == CNT_MAX) ? edge_q : edge_q + 32'd1;
        if (gate_q == GATE_LAST) begin
            gate_d  = '0;
            // An edge landing on the terminal cycle still belongs to this gate
            pinlv_d = rise_a_q ? edge_inc : edge_q;
            edge_d  = '0;
        end else if (rise_a_q) begin
            edge_d = edge_inc;
        end

        // Phase FSM
        state_d = state_q;
        per_d   = per_q;
        dly_d   = dly_q;
        d_lat_d = d_lat_q;
        phase_d = phase_q;
        per_inc = per_q + 32'd1;
        dly_inc = dly_q + 32'd1;
`ifdef PHASE_DEG_EN
        p_lat_d  = p_lat_q;
        step_d   = step_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        prod     = 44'(d_lat_q) * 44'd3600;
        dividend = ((prod >> DIV_W) != 44'd0) ? '1 : DIV_W'(prod);
        rem_sh   = {rem_q, quo_q[DIV_W-1]};
`endif

        case (state_q)
            IDLE: begin
                if (rise_a_q) begin
                    per_d   = '0;
                    dly_d   = '0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                per_d = per_inc;
                dly_d = dly_inc;
                if (per_q == CNT_MAX || dly_q == CNT_MAX) begin
                    per_d   = per_q;
                    dly_d   = dly_q;
                    state_d = IDLE;
                end else if (rise_b_q && rise_a_q) begin
                    // B edge is taken first, so the coincident A edge closes the period
                    d_lat_d = dly_inc;
`ifdef PHASE_DEG_EN
                    p_lat_d = per_inc;
`endif
                    state_d = DIV;
                end else if (rise_b_q) begin
                    state_d = WAIT_A;
                end else if (rise_a_q) begin
                    // A full period without a B edge: drop it and start over
                    per_d = '0;
                    dly_d = '0;
                end
            end
            WAIT_A: begin
                per_d = per_inc;
                if (per_q == CNT_MAX) begin
                    per_d   = per_q;
                    state_d = IDLE;
                end else if (rise_a_q) begin
                    d_lat_d = dly_q;
`ifdef PHASE_DEG_EN
                    p_lat_d = per_inc;
`endif
                    state_d = DIV;
                end
            end
            DIV: begin
`ifdef PHASE_DEG_EN
                step_d = step_q + 1'b1;
                if (step_q == '0) begin
                    rem_d = '0;
                    quo_d = dividend;
                    dvs_d = DIV_W'(p_lat_q);
                end else if (step_q <= STEP_W'(DIV_W)) begin
                    // Quotient bits shift in where dividend bits shift out
                    if (rem_sh >= {1'b0, dvs_q}) begin
                        rem_d = DIV_W'(rem_sh - {1'b0, dvs_q});
                        quo_d = {quo_q[DIV_W-2:0], 1'b1};
                    end else begin
                        rem_d = DIV_W'(rem_sh);
                        quo_d = {quo_q[DIV_W-2:0], 1'b0};
                    end
                end else begin
                    phase_d = (dvs_q == '0) ? 32'd0 : 32'(quo_q);
                    step_d  = '0;
                    state_d = IDLE;
                end
`else
                phase_d = 32'(DIV_W'(d_lat_q));
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_pipe_q <= '0;
            b_pipe_q <= '0;
            rise_a_q <= 1'b0;
            rise_b_q <= 1'b0;
            gate_q   <= '0;
            edge_q   <= '0;
            pinlv_q  <= '0;
            state_q  <= IDLE;
            per_q    <= '0;
            dly_q    <= '0;
            d_lat_q  <= '0;
            phase_q  <= '0;
`ifdef PHASE_DEG_EN
            p_lat_q  <= '0;
            step_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
`endif
        end else begin
            a_pipe_q <= a_pipe_d;
            b_pipe_q <= b_pipe_d;
            rise_a_q <= rise_a_d;
            rise_b_q <= rise_b_d;
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            pinlv_q  <= pinlv_d;
            state_q  <= state_d;
            per_q    <= per_d;
            dly_q    <= dly_d;
            d_lat_q  <= d_lat_d;
            phase_q  <= phase_d;
`ifdef PHASE_DEG_EN
            p_lat_q  <= p_lat_d;
            step_q   <= step_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
`endif
        end
    end

    assign io.phase = phase_q;
    assign io.pinlv = pinlv_q;
endmodule

// File: tb/tb_pro_uart_meas.sv
// tb/tb_pro_uart_meas.sv - Self-checking bench for pro_uart_meas
`timescale 1ns/1ps
module tb_pro_uart_meas;
    localparam int G = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #10 clk = ~clk;

    pro_uart_meas_if io();

    pro_uart_meas #(.GATE_CYCLES(G), .DIV_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int errors = 0;
    int checks = 0;
    int w = 0;
    int per_t = 100;
    int lag_l = 50;
    bit a_en = 1'b0, b_en = 1'b0, a_hold = 1'b0, b_hold = 1'b0;
    int periods[9] = '{20, 40, 50, 80, 100, 200, 250, 400, 500};

    // Reference: phase from lag and period alone
    function automatic logic [31:0] exp_phase(int t, int l);
`ifdef PHASE_DEG_EN
        return 32'((l * 3600) / t);
`else
        return 32'(l);
`endif
    endfunction

    function automatic logic [31:0] exp_pinlv(int t);
        return 32'(G / t);
    endfunction

    // Drive wave sample w at this negedge, then advance to the next negedge
    task automatic step();
        io.sig_in  = a_en ? ((w % per_t) < (per_t / 2)) : a_hold;
        io.sig_in1 = b_en ? (((w + per_t - lag_l) % per_t) < (per_t / 2)) : b_hold;
        w++;
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        io.sig_in = 1'b0;
        io.sig_in1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        w = 0;
    endtask

    task automatic check_outputs(string name, logic [31:0] ep, logic [31:0] ef);
        checks++;
        if (io.phase !== ep) begin
            errors++;
            $display("FAIL %s phase: got %0d expected %0d", name, io.phase, ep);
        end
        checks++;
        if (io.pinlv !== ef) begin
            errors++;
            $display("FAIL %s pinlv: got %0d expected %0d", name, io.pinlv, ef);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            io.sig_in = 1'($urandom);
            io.sig_in1 = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({io.phase, io.pinlv} !== 64'd0) begin
                errors++;
                $display("FAIL reset_hold: got phase=%0d pinlv=%0d expected 0/0", io.phase, io.pinlv);
            end
        end
        a_en = 1'b0; b_en = 1'b0; a_hold = 1'b0; b_hold = 1'b0;
        io.sig_in = 1'b0;
        io.sig_in1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        w = 0;
        for (int i = 0; i < G + 5; i++) begin
            step();
            if (i % 500 == 0) check_outputs("reset_release", 32'd0, 32'd0);
        end
        check_outputs("reset_gate_end", 32'd0, 32'd0);
    endtask

    task automatic test_scenario(string name, int t, int l);
        per_t = t; lag_l = l; a_en = 1'b1; b_en = 1'b1;
        do_reset();
        run(2 * G + 50);
        check_outputs(name, exp_phase(t, l), exp_pinlv(t));
    endtask

    task automatic test_latency();
`ifdef PHASE_DEG_EN
        int lat = 138;
`else
        int lat = 105;
`endif
        per_t = 100; lag_l = 50; a_en = 1'b1; b_en = 1'b1;
        do_reset();
        while (w < lat - 1) step();
        checks++;
        if (io.phase !== 32'd0) begin
            errors++;
            $display("FAIL latency_early: got %0d expected 0", io.phase);
        end
        step();
        checks++;
        if (io.phase !== exp_phase(100, 50)) begin
            errors++;
            $display("FAIL latency_on_time: got %0d expected %0d", io.phase, exp_phase(100, 50));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int t;
            int l;
            t = periods[$urandom_range(0, 8)];
            l = $urandom_range(1, t - 1);
            test_scenario($sformatf("random_T%0d_L%0d", t, l), t, l);
        end
    endtask

    task automatic test_b_low();
        test_scenario("quarter_lag", 100, 25);
        b_en = 1'b0; b_hold = 1'b0;
        run(2 * G + 50);
        check_outputs("b_held_low", exp_phase(100, 25), exp_pinlv(100));
    endtask

    task automatic test_a_stopped();
        a_en = 1'b0; a_hold = 1'b0;
        run(2 * G + 50);
        check_outputs("a_stopped", exp_phase(100, 25), 32'd0);
    endtask

    task automatic test_reset_mid_div();
        per_t = 100; lag_l = 50; a_en = 1'b1; b_en = 1'b1;
        do_reset();
        // Second measurement closes on posedge 304, so the FSM is in DIV here
        while (w < 304) step();
        checks++;
        if (io.phase !== exp_phase(100, 50)) begin
            errors++;
            $display("FAIL mid_div_before: got %0d expected %0d", io.phase, exp_phase(100, 50));
        end
        rst_n = 1'b1;
        #1;
        check_outputs("mid_div_reset", 32'd0, 32'd0);
        step();
        rst_n = 1'b0;
        run(2 * G + 50);
        check_outputs("mid_div_recover", exp_phase(100, 50), exp_pinlv(100));
    endtask

    initial begin
        io.sig_in = 1'b0;
        io.sig_in1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_scenario("half_lag", 100, 50);
        test_b_low();
        test_a_stopped();
        test_random();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pro_uart_meas.md
# pro_uart_meas

Dual-input frequency and phase meter feeding the host report path. It measures the frequency of reference input `sig_in` over a fixed gate window. It also measures the phase lag of `sig_in1` relative to `sig_in`. Results are presented as two 32-bit registered words that a downstream serializer reads at any time.

## Interface

Parameters:
- `GATE_CYCLES`, 50_000_000: clock cycles per frequency gate; 1 s at 50 MHz, so `pinlv` reads directly in Hz.
- `DIV_W`, 32: width of phase dividend, divisor and quotient.

Ports:
- `clk`, input, 1: system clock, 50 MHz nominal.
- `rst_n`, input, 1: asynchronous, active-high reset. The name is kept from the codebase; logic 1 resets.
- `sig_in`, input, 1: asynchronous reference square wave (A).
- `sig_in1`, input, 1: asynchronous second square wave (B).
- `phase`, output, 32: B lag relative to A; units set by Configuration.
- `pinlv`, output, 32: rising edges of A counted in the last complete gate.

## Operation

- **Input conditioning:** each input passes a 2-FF synchronizer, then a registered rising-edge detector, giving one-cycle pulses `rise_a` and `rise_b`.
- **Frequency counting:**
  - The gate counter runs 0..GATE_CYCLES-1 and wraps.
  - The edge counter increments on `rise_a`.
  - At terminal count: `pinlv` <= edge count, plus 1 if `rise_a` occurs in that same cycle. The edge counter then restarts at 0.
  - The edge counter saturates at 0xFFFF_FFFF.
- **Phase measurement FSM states:** IDLE, WAIT_B, WAIT_A, DIV.
  - **IDLE:** on `rise_a`, clear the period counter and the delay counter, go to WAIT_B.
  - **WAIT_B:** both counters increment each clock. On `rise_b`, freeze the delay counter and go to WAIT_A.
  - **Same-cycle edges in WAIT_B:** `rise_a` with no `rise_b` means no B edge arrived within the period. Discard the sample, restart both counters, stay in WAIT_B. If `rise_a` and `rise_b` arrive together, `rise_b` wins and the delay is latched first.
  - **WAIT_A:** the period counter continues. On `rise_a`, latch period P and delay D, go to DIV.
  - **Overflow:** if either counter would overflow, saturate it, discard the sample, and return to IDLE.
  - **DIV:** compute the result (see Configuration), load `phase`, go to IDLE. Edges arriving during DIV are ignored. The next measurement starts on the first `rise_a` after returning to IDLE.
- **Zero period:** P = 0 cannot occur, because P ≥ 1 by construction. The divider still treats a zero divisor as result 0.
- **No B activity:** `phase` holds its last value.
- **No A activity:** `pinlv` becomes 0 at the next gate end.

## Timing

- Reset (rst_n=1): `phase`=0, `pinlv`=0, all counters 0, FSM=IDLE, synchronizer flops 0.
- Input-to-pulse latency: 3 clocks (2 sync + edge register).
- `pinlv` updates one clock after gate terminal count and then holds for exactly GATE_CYCLES clocks.
- `phase` updates after DIV completes:
  - divider mode: 34 clocks after the closing `rise_a` (1 load + 32 iterations + 1 output);
  - raw mode: 1 clock.
- Reset asserted mid-gate or mid-division aborts immediately. The first gate after release begins at gate count 0.
- Outputs change only on `clk` rising edges and are glitch-free registers.

## Configuration

- **Macro `PHASE_DEG_EN`:**
  - Defined: `phase` = floor(D × 3600 / P), in 0.1° units, range 0..3599.
  - The divider is a sequential restoring divider of DIV_W iterations.
  - D × 3600 uses a 44-bit intermediate product, truncated to DIV_W bits. D < P ≤ 2^20 is required for an exact result; larger D saturates the dividend at 0xFFFF_FFFF.
- **Undefined:** `phase` = D, the raw lag in clock cycles. The divider is not built and DIV lasts 1 clock.

## Test plan

- **Reset:** hold rst_n=1 with toggling inputs. Required: `phase`=0 and `pinlv`=0 throughout, and both stay 0 for one gate after release.
- **Frequency and half-period lag:** GATE_CYCLES=50_000, 50 MHz clk, A = 500 kHz square wave, B = ~A. Required: `pinlv`=500 after each gate, and `phase`=1800 with PHASE_DEG_EN (50 without).
- **Quarter-period lag:** A = 500 kHz, B delayed 500 ns. Required: `phase`=900 (raw mode: 25).
- **B held low:** A = 500 kHz, B constant 0 after one valid sample. Required: `phase` holds its previous value and `pinlv` stays 500.
- **A stopped:** A held constant for a full gate. Required: `pinlv`=0 at the next gate end.
- **Reset mid-division:** assert rst_n for 1 clock during DIV. Required: `phase`=0 at once, and the next valid sample reproduces the correct value.
